// File: rtl/wb_port_sequencer.sv
// Writeback port sequencer: turns one retiring instruction into zero, one or two
// register-file write cycles on a single write port (popq needs two).
module wb_port_sequencer #(
   parameter int DATA_W  = 64,
   parameter int NREG    = 15,
   parameter int RSP_IDX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        icode,
   input  logic              Cnd,
   input  logic [3:0]        rA,
   input  logic [3:0]        rB,
   input  logic [DATA_W-1:0] valE,
   input  logic [DATA_W-1:0] valM,
   output logic              wr_en,
   output logic [3:0]        wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              done,
   output logic              busy,
   output logic              instr_err
);

   typedef enum logic [1:0] {IDLE, W1, W2} state_t;

   localparam logic [3:0] RSP_ADDR = 4'(RSP_IDX);
   localparam logic [3:0] IC_POPQ  = 4'hB;

   state_t              state, state_nx;
   logic [3:0]          cap_icode, cap_ra;
   logic [DATA_W-1:0]   cap_valm;

   logic                dec_sel, dec_en;
   logic [3:0]          dec_addr;
   logic [DATA_W-1:0]   dec_data;

   logic                wr_en_nx, done_nx, err_nx;
   logic [3:0]          wr_addr_nx;
   logic [DATA_W-1:0]   wr_data_nx;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // First-write decode, evaluated on the incoming operands so the W1 outputs
   // can be loaded into registers at the accept edge.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      dec_sel  = 1'b1;
      dec_en   = 1'b1;
      dec_addr = rB;
      dec_data = valE;
      case (icode)
         4'h2:                dec_en = Cnd;
         4'h3, 4'h6:          ;
         4'h5: begin
            dec_addr = rA;
            dec_data = valM;
         end
         4'h8, 4'h9, 4'hA, 4'hB: dec_addr = RSP_ADDR;
         default: begin
            dec_sel = 1'b0;
            dec_en  = 1'b0;
         end
      endcase
      if (int'(dec_addr) >= NREG) dec_en = 1'b0;
   end

   always_comb begin
      state_nx   = state;
      wr_en_nx   = 1'b0;
      done_nx    = 1'b0;
      wr_addr_nx = wr_addr;
      wr_data_nx = wr_data;
      err_nx     = instr_err;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nx = W1;
               wr_en_nx = dec_en;
               done_nx  = (icode != IC_POPQ);
               if (dec_sel) begin
                  wr_addr_nx = dec_addr;
                  wr_data_nx = dec_data;
               end
               if (icode >= 4'hC) err_nx = 1'b1;
            end
         end
         W1: begin
            if (cap_icode == IC_POPQ) begin
               // Second popq write lands after the %rsp update, so rA=%rsp ends at valM.
               state_nx   = W2;
               wr_en_nx   = (int'(cap_ra) < NREG);
               wr_addr_nx = cap_ra;
               wr_data_nx = cap_valm;
               done_nx    = 1'b1;
            end else begin
               state_nx = IDLE;
            end
         end
         W2:      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         done      <= 1'b0;
         instr_err <= 1'b0;
         cap_icode <= '0;
         cap_ra    <= '0;
         cap_valm  <= '0;
      end else begin
         state     <= state_nx;
         wr_en     <= wr_en_nx;
         wr_addr   <= wr_addr_nx;
         wr_data   <= wr_data_nx;
         done      <= done_nx;
         instr_err <= err_nx;
         if (state == IDLE && in_valid) begin
            cap_icode <= icode;
            cap_ra    <= rA;
            cap_valm  <= valM;
         end
      end
   end

endmodule
